// File: rtl/write_buffer_pkg.sv
// Shared constants for the posted-write buffer: default sizing and the
// state encoding the cache top uses when it sizes its stall logic.
package write_buffer_pkg;

  localparam int WB_DEPTH  = 4;
  localparam int WB_ADDR_W = 32;
  localparam int WB_DATA_W = 32;

  localparam logic [1:0] WB_S_IDLE  = 2'd0;
  localparam logic [1:0] WB_S_DRAIN = 2'd1;
  localparam logic [1:0] WB_S_FLUSH = 2'd2;

endpackage

// File: rtl/write_buffer_if.sv
// Cache-side and memory-side signals of the write buffer. The buffer is the
// slave; the cache plus memory environment is the master.
interface write_buffer_if
  import write_buffer_pkg::*;
#(
  parameter int ADDR_WIDTH = WB_ADDR_W,
  parameter int DATA_WIDTH = WB_DATA_W
);
  logic                  c_wen;
  logic                  c_ren;
  logic [ADDR_WIDTH-1:0] c_addr;
  logic [DATA_WIDTH-1:0] c_wdata;
  logic [DATA_WIDTH-1:0] c_rdata;
  logic                  flush;
  logic                  full;
  logic                  empty;
  logic                  flush_done;
  logic                  m_ready;
  logic                  m_wen;
  logic [ADDR_WIDTH-1:0] m_addr;
  logic [DATA_WIDTH-1:0] m_wdata;
  logic [DATA_WIDTH-1:0] m_rdata;

  modport master (
    output c_wen, c_ren, c_addr, c_wdata, flush, m_ready, m_rdata,
    input  c_rdata, full, empty, flush_done, m_wen, m_addr, m_wdata
  );

  modport slave (
    input  c_wen, c_ren, c_addr, c_wdata, flush, m_ready, m_rdata,
    output c_rdata, full, empty, flush_done, m_wen, m_addr, m_wdata
  );
endinterface

// File: rtl/write_buffer_fifo.sv
// Circular word store for the write buffer: valid bits, head/tail/count,
// word-address matching with youngest-entry selection for coalesce and forward.
module wb_fifo
  import write_buffer_pkg::*;
#(
  parameter int DEPTH      = WB_DEPTH,
  parameter int ADDR_WIDTH = WB_ADDR_W,
  parameter int DATA_WIDTH = WB_DATA_W,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic                  pop,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [ADDR_WIDTH-1:0] head_addr,
  output logic [DATA_WIDTH-1:0] head_data,
  output logic [CW-1:0]         count,
  output logic [CW-1:0]         count_next,
  output logic                  rd_hit,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [ADDR_WIDTH-1:0] addr_q [DEPTH];
  logic [DATA_WIDTH-1:0] data_q [DEPTH];
  logic [DEPTH-1:0]      valid;
  logic [PW-1:0]         head, tail;
  logic [DEPTH-1:0]      match;
  logic                  wr_hit, push;
  logic [PW-1:0]         wr_idx, rd_idx;

  // Walk from oldest to youngest so the last hit wins; the popping head is
  // never a coalesce target because its data is already on the memory bus.
  always_comb begin
    logic [PW-1:0] idx;
    idx    = '0;
    match  = '0;
    rd_hit = 1'b0;
    rd_idx = '0;
    wr_hit = 1'b0;
    wr_idx = '0;
    for (int i = 0; i < DEPTH; i++)
      match[i] = valid[i] && (addr_q[i][ADDR_WIDTH-1:2] == addr[ADDR_WIDTH-1:2]);
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PW'(i);
      if (match[idx]) begin
        rd_hit = 1'b1;
        rd_idx = idx;
        if (!(pop && (idx == head))) begin
          wr_hit = 1'b1;
          wr_idx = idx;
        end
      end
    end
  end

  assign push       = wr_en && !wr_hit;
  assign count_next = count + CW'(push) - CW'(pop);
  assign head_addr  = addr_q[head];
  assign head_data  = data_q[head];
  assign rd_data    = data_q[rd_idx];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid <= '0;
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      count <= count_next;
      if (pop) begin
        valid[head] <= 1'b0;
        head        <= head + 1'b1;
      end
      if (push) begin
        valid[tail] <= 1'b1;
        tail        <= tail + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      if (wr_hit) begin
        data_q[wr_idx] <= wdata;
      end else begin
        addr_q[tail] <= addr;
        data_q[tail] <= wdata;
      end
    end
  end

endmodule

// File: rtl/write_buffer.sv
// Posted-write buffer between the cache memory port and main memory:
// flush FSM, memory-port priority mux and read forwarding around wb_fifo.
module write_buffer
  import write_buffer_pkg::*;
#(
  parameter int DEPTH      = WB_DEPTH,
  parameter int ADDR_WIDTH = WB_ADDR_W,
  parameter int DATA_WIDTH = WB_DATA_W
) (
  input logic           clk,
  input logic           reset,
  write_buffer_if.slave bus
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [1:0]            state;
  logic                  full_q, empty_q, flush_done_q;
  logic                  enq, drain, pop, rd_hit;
  logic [ADDR_WIDTH-1:0] head_addr;
  logic [DATA_WIDTH-1:0] head_data, rd_data;
  logic [CW-1:0]         count, count_next;

  assign enq   = bus.c_wen && !full_q && (state != WB_S_FLUSH);
  assign drain = !bus.c_ren && (count != '0);
  assign pop   = drain && bus.m_ready;

  wb_fifo #(
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .wr_en      (enq),
    .pop        (pop),
    .addr       (bus.c_addr),
    .wdata      (bus.c_wdata),
    .head_addr  (head_addr),
    .head_data  (head_data),
    .count      (count),
    .count_next (count_next),
    .rd_hit     (rd_hit),
    .rd_data    (rd_data)
  );

  // A line fill owns the memory port; buffered writes drain only when it is idle.
  always_comb begin
    bus.m_wen   = drain;
    bus.m_addr  = '0;
    bus.m_wdata = '0;
    if (bus.c_ren) begin
      bus.m_addr = bus.c_addr;
    end else if (drain) begin
      bus.m_addr  = head_addr;
      bus.m_wdata = head_data;
    end
  end

  assign bus.c_rdata    = rd_hit ? rd_data : bus.m_rdata;
  assign bus.full       = full_q;
  assign bus.empty      = empty_q;
  assign bus.flush_done = flush_done_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= WB_S_IDLE;
      full_q       <= 1'b0;
      empty_q      <= 1'b1;
      flush_done_q <= 1'b0;
    end else begin
      full_q       <= (count_next == CW'(DEPTH));
      empty_q      <= (count_next == '0);
      flush_done_q <= 1'b0;
      case (state)
        WB_S_FLUSH: begin
          if (count_next == '0) begin
            flush_done_q <= 1'b1;
            state        <= WB_S_IDLE;
          end
        end
        default: begin
          if (bus.flush) begin
            if (count_next == '0) begin
              flush_done_q <= 1'b1;
              state        <= WB_S_IDLE;
            end else begin
              state <= WB_S_FLUSH;
            end
          end else begin
            state <= (count_next == '0) ? WB_S_IDLE : WB_S_DRAIN;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_write_buffer.sv
// Bench for write_buffer: directed scenarios with literal expectations plus a
// randomized run, all checked every cycle against a queue-based model.
module tb_write_buffer;

  localparam int DEPTH = 4;

  logic clk;
  logic reset;

  write_buffer_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  write_buffer #(.DEPTH(DEPTH), .ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: oldest entry at index 0, plus flush bookkeeping.
  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
  } ent_t;

  ent_t        q[$];
  bit          flushing = 0;
  bit          done_exp = 0;
  bit          mw, popm, acc;
  int          hit;
  logic [31:0] exp_addr, exp_wdata, exp_rdata;

  // Outputs are stable mid-cycle and inputs are held until after the next
  // rising edge, so the model advances here right after checking.
  always @(negedge clk) begin
    if (reset) begin
      q.delete();
      flushing = 0;
      done_exp = 0;
    end
    mw        = !bus.c_ren && (q.size() > 0);
    exp_addr  = bus.c_ren ? bus.c_addr : (q.size() > 0 ? q[0].a : 32'h0);
    exp_wdata = mw ? q[0].d : 32'h0;
    exp_rdata = bus.m_rdata;
    for (int i = 0; i < q.size(); i++)
      if (q[i].a[31:2] == bus.c_addr[31:2]) exp_rdata = q[i].d;
    chk("m_wen", {31'h0, bus.m_wen}, {31'h0, mw});
    chk("m_addr", bus.m_addr, exp_addr);
    chk("m_wdata", bus.m_wdata, exp_wdata);
    chk("c_rdata", bus.c_rdata, exp_rdata);
    chk("full", {31'h0, bus.full}, {31'h0, q.size() == DEPTH});
    chk("empty", {31'h0, bus.empty}, {31'h0, q.size() == 0});
    chk("flush_done", {31'h0, bus.flush_done}, {31'h0, done_exp});
    if (!reset) begin
      popm = mw && bus.m_ready;
      acc  = bus.c_wen && (q.size() < DEPTH) && !flushing;
      hit  = -1;
      if (acc)
        for (int i = q.size() - 1; i >= (popm ? 1 : 0); i--)
          if (hit < 0 && q[i].a[31:2] == bus.c_addr[31:2]) hit = i;
      if (acc && hit >= 0) q[hit].d = bus.c_wdata;
      if (popm) void'(q.pop_front());
      if (acc && hit < 0) q.push_back('{bus.c_addr, bus.c_wdata});
      done_exp = 0;
      if (flushing) begin
        if (q.size() == 0) begin
          done_exp = 1;
          flushing = 0;
        end
      end else if (bus.flush) begin
        if (q.size() == 0) done_exp = 1;
        else flushing = 1;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.c_wen   = 1'b0;
    bus.c_ren   = 1'b0;
    bus.c_addr  = 32'h0;
    bus.c_wdata = 32'h0;
    bus.flush   = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    bus.c_wen   = 1'b1;
    bus.c_addr  = a;
    bus.c_wdata = d;
    step();
    bus.c_wen = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    bus.m_ready = 1'b0;
    bus.m_rdata = 32'hCAFE_0001;
    reset = 1'b1;
    step();
    step();
    @(negedge clk);
    chk("rst_empty", {31'h0, bus.empty}, 32'h1);
    chk("rst_m_wen", {31'h0, bus.m_wen}, 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Single write drains next cycle
    bus.m_ready = 1'b1;
    wr(32'h100, 32'hDEADBEEF);
    @(negedge clk);
    chk("single_m_wen", {31'h0, bus.m_wen}, 32'h1);
    chk("single_m_addr", bus.m_addr, 32'h100);
    chk("single_m_wdata", bus.m_wdata, 32'hDEADBEEF);
    step();
    @(negedge clk);
    chk("single_empty", {31'h0, bus.empty}, 32'h1);

    // Fill to full, extra write dropped, then in-order drain
    step();
    bus.m_ready = 1'b0;
    for (int k = 0; k < 4; k++) wr(32'(4 * k), 32'hA0 + 32'(k));
    @(negedge clk);
    chk("fill_full", {31'h0, bus.full}, 32'h1);
    step();
    wr(32'h10, 32'hBAD);
    @(negedge clk);
    chk("fill_still_full", {31'h0, bus.full}, 32'h1);
    step();
    bus.m_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("drain_addr", bus.m_addr, 32'(4 * k));
      chk("drain_data", bus.m_wdata, 32'hA0 + 32'(k));
      step();
    end
    @(negedge clk);
    chk("drain_empty", {31'h0, bus.empty}, 32'h1);
    chk("drain_no_stale", {31'h0, bus.m_wen}, 32'h0);

    // Coalesce and forward
    step();
    bus.m_ready = 1'b0;
    wr(32'h20, 32'h11);
    wr(32'h20, 32'h22);
    bus.c_ren  = 1'b1;
    bus.c_addr = 32'h20;
    @(negedge clk);
    chk("fwd_hit", bus.c_rdata, 32'h22);
    chk("fwd_no_wen", {31'h0, bus.m_wen}, 32'h0);
    step();
    bus.c_addr  = 32'h24;
    bus.m_rdata = 32'h5A5A_5A5A;
    @(negedge clk);
    chk("fwd_miss", bus.c_rdata, 32'h5A5A_5A5A);
    step();
    bus.c_ren   = 1'b0;
    bus.m_ready = 1'b1;
    @(negedge clk);
    chk("coal_data", bus.m_wdata, 32'h22);
    step();
    @(negedge clk);
    chk("coal_single_entry", {31'h0, bus.empty}, 32'h1);

    // Read priority holds off the drain
    step();
    bus.m_ready = 1'b0;
    wr(32'h40, 32'h1);
    wr(32'h44, 32'h2);
    bus.m_ready = 1'b1;
    bus.c_ren   = 1'b1;
    bus.c_addr  = 32'h80;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("rdpri_m_wen", {31'h0, bus.m_wen}, 32'h0);
      chk("rdpri_m_addr", bus.m_addr, 32'h80);
      step();
    end
    bus.c_ren = 1'b0;
    @(negedge clk);
    chk("rdpri_resume0", bus.m_addr, 32'h40);
    step();
    @(negedge clk);
    chk("rdpri_resume1", bus.m_addr, 32'h44);
    step();

    // Flush with three entries; write during flush is dropped
    bus.m_ready = 1'b0;
    wr(32'h60, 32'h6);
    wr(32'h64, 32'h7);
    wr(32'h68, 32'h8);
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    wr(32'h6C, 32'h9);
    bus.m_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("flush_addr", bus.m_addr, 32'h60 + 32'(4 * k));
      chk("flush_not_done", {31'h0, bus.flush_done}, 32'h0);
      step();
    end
    @(negedge clk);
    chk("flush_done", {31'h0, bus.flush_done}, 32'h1);
    chk("flush_dropped", {31'h0, bus.m_wen}, 32'h0);
    step();
    @(negedge clk);
    chk("flush_pulse_end", {31'h0, bus.flush_done}, 32'h0);

    // Flush while empty
    step();
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    @(negedge clk);
    chk("flush_empty_done", {31'h0, bus.flush_done}, 32'h1);
    step();
    @(negedge clk);
    chk("flush_empty_end", {31'h0, bus.flush_done}, 32'h0);

    // Asynchronous reset mid-drain
    step();
    bus.m_ready = 1'b0;
    wr(32'h200, 32'h1);
    wr(32'h204, 32'h2);
    wr(32'h208, 32'h3);
    bus.m_ready = 1'b1;
    step();
    #2;
    reset = 1'b1;
    #1;
    chk("arst_m_wen", {31'h0, bus.m_wen}, 32'h0);
    chk("arst_full", {31'h0, bus.full}, 32'h0);
    chk("arst_empty", {31'h0, bus.empty}, 32'h1);
    chk("arst_flush_done", {31'h0, bus.flush_done}, 32'h0);
    @(posedge clk);
    #3;
    reset = 1'b0;
    for (int k = 0; k < 2; k++) begin
      step();
      @(negedge clk);
      chk("arst_no_stale", {31'h0, bus.m_wen}, 32'h0);
    end
    step();

    // Randomized traffic on a small address window to exercise coalescing
    for (int n = 0; n < 3000; n++) begin
      bus.c_wen   = ($urandom_range(0, 99) < 45);
      bus.c_ren   = ($urandom_range(0, 99) < 25);
      bus.c_addr  = 32'($urandom_range(0, 15)) * 4 + 32'($urandom_range(0, 3));
      bus.c_wdata = $urandom;
      bus.flush   = ($urandom_range(0, 99) < 3);
      bus.m_ready = ($urandom_range(0, 99) < 60);
      bus.m_rdata = $urandom;
      step();
    end
    idle_inputs();
    bus.m_ready = 1'b1;
    repeat (8) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
